// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: frame FSM states, op codes and the
// frame/command consistency rule.
package spi_slave_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   // The op carried in the frame must agree with the path chosen by the cmd bit.
   function automatic logic op_matches(input state_t st, input logic [1:0] op);
      case (st)
         WRITE:     return (op == OP_WR_ADDR) || (op == OP_WR_DATA);
         READ_ADD:  return op == OP_RD_ADDR;
         READ_DATA: return op == OP_RD_DATA;
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/spi_slave_param_tx.sv
// MISO serialiser: loads a RAM word, drives its MSB at once, then one bit per
// shift cycle, and returns MISO to 0 after the LSB.
module spi_tx_shifter #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic              clear,
   input  logic [WORD_W-1:0] data,
   output logic              miso,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] shreg;
   logic [CW-1:0]     bits_left;

   assign done = busy && (bits_left == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miso      <= 1'b0;
         busy      <= 1'b0;
         shreg     <= '0;
         bits_left <= '0;
      end else if (clear) begin
         miso      <= 1'b0;
         busy      <= 1'b0;
         shreg     <= '0;
         bits_left <= '0;
      end else if (load) begin
         miso      <= data[WORD_W-1];
         shreg     <= {data[WORD_W-2:0], 1'b0};
         bits_left <= CW'(WORD_W - 1);
         busy      <= 1'b1;
      end else if (shift && busy) begin
         if (done) begin
            miso <= 1'b0;
            busy <= 1'b0;
         end else begin
            miso      <= shreg[WORD_W-1];
            shreg     <= {shreg[WORD_W-2:0], 1'b0};
            bits_left <= bits_left - CW'(1);
         end
      end
   end

endmodule

// File: rtl/spi_slave_param.sv
// SPI mode-0 slave: deframes {op, word} command frames for the RAM and returns
// read data on MISO, flagging aborted, inconsistent or timed-out frames.
module spi_slave_param
   import spi_slave_pkg::*;
#(
   parameter int WORD_W     = 8,
   parameter int TX_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [WORD_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              frame_err
);

   localparam int            CNT_W = $clog2(WORD_W + 3);
   localparam int            TO_W  = $clog2(TX_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_W + 2);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W + 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TX_TIMEOUT - 1);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [WORD_W:0]     shift_reg, shift_nxt;
   logic [WORD_W+1:0]   rx_data_nxt;
   logic                rx_valid_nxt, frame_err_nxt;
   logic                rd_addr_seen, rd_seen_nxt;
   logic                waiting, waiting_nxt;
   logic [TO_W-1:0]     to_cnt, to_cnt_nxt;
   logic                tx_load, tx_shift, tx_clear, tx_busy, tx_done;
   logic [WORD_W+1:0]   frame;

   assign frame = {shift_reg, MOSI};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         shift_reg    <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         rd_addr_seen <= 1'b0;
         waiting      <= 1'b0;
         to_cnt       <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         shift_reg    <= shift_nxt;
         rx_data      <= rx_data_nxt;
         rx_valid     <= rx_valid_nxt;
         frame_err    <= frame_err_nxt;
         rd_addr_seen <= rd_seen_nxt;
         waiting      <= waiting_nxt;
         to_cnt       <= to_cnt_nxt;
      end
   end

   // A saturated counter (FULL) marks a frame whose payload is complete, so a
   // later SS_n release is a clean end rather than an abort.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      shift_nxt     = shift_reg;
      rx_data_nxt   = rx_data;
      rx_valid_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
      rd_seen_nxt   = rd_addr_seen;
      waiting_nxt   = waiting;
      to_cnt_nxt    = to_cnt;
      tx_load       = 1'b0;
      tx_shift      = 1'b0;
      tx_clear      = 1'b0;
      case (state)
         IDLE: begin
            if (!SS_n) begin
               state_nxt   = CHK_CMD;
               cnt_nxt     = '0;
               waiting_nxt = 1'b0;
            end
         end
         default: begin
            if (SS_n) begin
               state_nxt   = IDLE;
               tx_clear    = 1'b1;
               waiting_nxt = 1'b0;
               if (cnt != FULL)
                  frame_err_nxt = 1'b1;
            end else if (state == CHK_CMD) begin
               if (!MOSI)
                  state_nxt = WRITE;
               else if (rd_addr_seen)
                  state_nxt = READ_DATA;
               else
                  state_nxt = READ_ADD;
            end else if (cnt != FULL) begin
               shift_nxt = frame[WORD_W:0];
               cnt_nxt   = cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  if (op_matches(state, frame[WORD_W+1:WORD_W])) begin
                     rx_data_nxt  = frame;
                     rx_valid_nxt = 1'b1;
                     if (state == READ_ADD)
                        rd_seen_nxt = 1'b1;
                     if (state == READ_DATA) begin
                        waiting_nxt = 1'b1;
                        to_cnt_nxt  = '0;
                     end
                  end else begin
                     frame_err_nxt = 1'b1;
                  end
               end
            end else if (state == READ_DATA) begin
               if (waiting) begin
                  if (tx_valid) begin
                     tx_load     = 1'b1;
                     waiting_nxt = 1'b0;
                  end else if (to_cnt == TO_LAST) begin
                     frame_err_nxt = 1'b1;
                     waiting_nxt   = 1'b0;
                  end else begin
                     to_cnt_nxt = to_cnt + TO_W'(1);
                  end
               end else if (tx_busy) begin
                  tx_shift = 1'b1;
                  if (tx_done)
                     rd_seen_nxt = 1'b0;
               end
            end
         end
      endcase
   end

   spi_tx_shifter #(.WORD_W(WORD_W)) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tx_load),
      .shift (tx_shift),
      .clear (tx_clear),
      .data  (tx_data),
      .miso  (MISO),
      .busy  (tx_busy),
      .done  (tx_done)
   );

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param with an 8-bit and a 16-bit instance.
module tb_spi_slave_param;
   import spi_slave_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
   logic        tx_valid = 1'b0, sel16 = 1'b0;
   logic        ss8, ss16;
   logic [7:0]  tx_data8 = '0;
   logic [15:0] tx_data16 = '0;
   logic        miso8, rx_valid8, frame_err8;
   logic        miso16, rx_valid16, frame_err16;
   logic [9:0]  rx_data8;
   logic [17:0] rx_data16;
   logic [15:0] exp_word;

   int check_count = 0, pass_count = 0;
   int rx_count8 = 0, err_count8 = 0, rx_count16 = 0, err_count16 = 0, both_high = 0;
   int exp_rx8 = 0, exp_err8 = 0, exp_rx16 = 0, exp_err16 = 0;
   int k;

   assign ss8  = sel16 ? 1'b1 : SS_n;
   assign ss16 = sel16 ? SS_n : 1'b1;

   always #5 clk = ~clk;

   spi_slave_param #(.WORD_W(8), .TX_TIMEOUT(16)) dut8 (
      .clk(clk), .rst_n(rst_n), .SS_n(ss8), .MOSI(MOSI), .MISO(miso8),
      .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_data(tx_data8),
      .tx_valid(tx_valid), .frame_err(frame_err8)
   );

   spi_slave_param #(.WORD_W(16), .TX_TIMEOUT(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .SS_n(ss16), .MOSI(MOSI), .MISO(miso16),
      .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16),
      .tx_valid(tx_valid), .frame_err(frame_err16)
   );

   // Strobe counters; sampled on the edge after each one-cycle pulse.
   always @(posedge clk) begin
      if (rx_valid8)   rx_count8   <= rx_count8 + 1;
      if (frame_err8)  err_count8  <= err_count8 + 1;
      if (rx_valid16)  rx_count16  <= rx_count16 + 1;
      if (frame_err16) err_count16 <= err_count16 + 1;
      if ((rx_valid8 && frame_err8) || (rx_valid16 && frame_err16))
         both_high <= both_high + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed === expected)
         pass_count++;
      else
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic cmd, input logic [17:0] payload, input int nbits,
                                input int nsend, input logic release_ss);
      @(negedge clk) SS_n = 1'b0;
      @(negedge clk) MOSI = cmd;
      for (int i = 0; i < nsend; i++) begin
         @(negedge clk) MOSI = payload[nbits-1-i];
      end
      if (release_ss) begin
         @(negedge clk);
         SS_n = 1'b1;
         MOSI = 1'b0;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("rst_miso8", miso8, 0);
      checkOutput("rst_rx_data8", rx_data8, 0);
      checkOutput("rst_rx_valid8", rx_valid8, 0);
      checkOutput("rst_frame_err8", frame_err8, 0);
      checkOutput("rst_rx_data16", rx_data16, 0);
      checkOutput("rst_miso16", miso16, 0);
      rst_n = 1'b1;

      // Write address and write data frames
      applyStimulus(1'b0, 18'h000FF, 10, 10, 1'b1);
      repeat (2) @(negedge clk);
      exp_rx8++;
      checkOutput("t1_rx_data", rx_data8, 10'h0FF);
      checkOutput("t1_rx_count", rx_count8, exp_rx8);
      checkOutput("t1_err_count", err_count8, exp_err8);

      applyStimulus(1'b0, 18'h0017D, 10, 10, 1'b1);
      repeat (2) @(negedge clk);
      exp_rx8++;
      checkOutput("t2_wr_data", rx_data8, 10'h17D);
      applyStimulus(1'b1, 18'h002FF, 10, 10, 1'b1);
      repeat (2) @(negedge clk);
      exp_rx8++;
      checkOutput("t2_rd_addr", rx_data8, 10'h2FF);
      checkOutput("t2_rd_seen", dut8.rd_addr_seen, 1);
      checkOutput("t2_rx_count", rx_count8, exp_rx8);

      // Read data frame, RAM answers two cycles after rx_valid
      applyStimulus(1'b1, 18'h00300, 10, 10, 1'b0);
      @(negedge clk);
      checkOutput("t3_rx_valid", rx_valid8, 1);
      checkOutput("t3_rx_data", rx_data8, 10'h300);
      checkOutput("t3_miso_idle", miso8, 0);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data8 = 8'h7D;
      exp_word = 16'h007D;
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         tx_valid = 1'b0;
         tx_data8 = 8'h00;
         checkOutput($sformatf("t3_miso_bit%0d", i), miso8, exp_word[i]);
      end
      @(negedge clk);
      checkOutput("t3_miso_after", miso8, 0);
      checkOutput("t3_rd_seen", dut8.rd_addr_seen, 0);
      SS_n = 1'b1;
      repeat (2) @(negedge clk);
      exp_rx8++;
      checkOutput("t3_rx_count", rx_count8, exp_rx8);
      checkOutput("t3_err_count", err_count8, exp_err8);

      // Abort after five payload bits, then a normal frame
      applyStimulus(1'b0, 18'h000FF, 10, 5, 1'b1);
      @(negedge clk);
      checkOutput("t4_frame_err", frame_err8, 1);
      checkOutput("t4_rx_valid", rx_valid8, 0);
      checkOutput("t4_state", dut8.state, IDLE);
      @(negedge clk);
      exp_err8++;
      checkOutput("t4_err_count", err_count8, exp_err8);
      applyStimulus(1'b0, 18'h001A5, 10, 10, 1'b1);
      repeat (2) @(negedge clk);
      exp_rx8++;
      checkOutput("t4_rx_data", rx_data8, 10'h1A5);
      checkOutput("t4_rx_count", rx_count8, exp_rx8);

      // Read-data op on the read-address path is inconsistent
      applyStimulus(1'b1, 18'h00300, 10, 10, 1'b0);
      @(negedge clk);
      checkOutput("t5_bad_op_err", frame_err8, 1);
      checkOutput("t5_bad_op_rx", rx_valid8, 0);
      SS_n = 1'b1;
      repeat (2) @(negedge clk);
      exp_err8++;
      checkOutput("t5_rx_data_kept", rx_data8, 10'h1A5);
      checkOutput("t5_err_count", err_count8, exp_err8);
      checkOutput("t5_rx_count", rx_count8, exp_rx8);

      // Read data with no RAM answer: timeout
      applyStimulus(1'b1, 18'h00201, 10, 10, 1'b1);
      repeat (2) @(negedge clk);
      exp_rx8++;
      checkOutput("t5_rd_seen_set", dut8.rd_addr_seen, 1);
      applyStimulus(1'b1, 18'h00300, 10, 10, 1'b0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!frame_err8 && k < 40);
      checkOutput("t5_timeout_cycles", k, 17);
      checkOutput("t5_timeout_miso", miso8, 0);
      SS_n = 1'b1;
      repeat (2) @(negedge clk);
      exp_rx8++;
      exp_err8++;
      checkOutput("t5_to_rx_count", rx_count8, exp_rx8);
      checkOutput("t5_to_err_count", err_count8, exp_err8);
      checkOutput("t5_rd_seen_kept", dut8.rd_addr_seen, 1);

      // 16-bit instance
      sel16 = 1'b1;
      rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      applyStimulus(1'b0, 18'h01234, 18, 18, 1'b1);
      repeat (2) @(negedge clk);
      exp_rx16++;
      checkOutput("t6_wr_addr", rx_data16, 18'h01234);
      applyStimulus(1'b1, 18'h20056, 18, 18, 1'b1);
      repeat (2) @(negedge clk);
      exp_rx16++;
      checkOutput("t6_rd_addr", rx_data16, 18'h20056);
      applyStimulus(1'b1, 18'h30000, 18, 18, 1'b0);
      @(negedge clk);
      checkOutput("t6_rd_data", rx_data16, 18'h30000);
      tx_valid  = 1'b1;
      tx_data16 = 16'hA5C3;
      exp_word  = 16'hA5C3;
      for (int i = 15; i >= 0; i--) begin
         @(negedge clk);
         tx_valid  = 1'b0;
         tx_data16 = 16'h0000;
         checkOutput($sformatf("t6_miso_bit%0d", i), miso16, exp_word[i]);
      end
      @(negedge clk);
      checkOutput("t6_miso_after", miso16, 0);
      SS_n = 1'b1;
      repeat (2) @(negedge clk);
      exp_rx16++;
      checkOutput("t6_rx_count", rx_count16, exp_rx16);
      checkOutput("t6_err_count", err_count16, exp_err16);
      checkOutput("t6_rd_seen_clr", dut16.rd_addr_seen, 0);

      // Reset in the middle of shift-out
      applyStimulus(1'b1, 18'h20056, 18, 18, 1'b1);
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 18'h30000, 18, 18, 1'b0);
      @(negedge clk);
      tx_valid  = 1'b1;
      tx_data16 = 16'hA5C3;
      repeat (3) begin
         @(negedge clk);
         tx_valid = 1'b0;
      end
      checkOutput("t6_miso_pre_rst", miso16, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_miso", miso16, 0);
      checkOutput("t6_rst_state", dut16.state, IDLE);
      checkOutput("t6_rst_rd_seen", dut16.rd_addr_seen, 0);
      @(negedge clk);
      SS_n  = 1'b1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      checkOutput("never_both_high", both_high, 0);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised SPI slave (mode 0, MSB-first) that deframes MOSI command frames into a RAM-side request bus and serialises RAM read data onto MISO. It is the next-generation slave core beside the single-port RAM inside the SPI top level. Word width is generic. Added over the previous slave: frame-abort detection, frame/command consistency checking, and a read-data timeout.

Parameters:
WORD_W, 8, address/data word width; frame payload is WORD_W+2 bits ({op[1:0], word}).
TX_TIMEOUT, 16, max clk cycles to wait for tx_valid in READ_DATA before error; must be >=1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
SS_n  in  1  slave select, active low
MOSI  in  1  serial data in
MISO  out  1  serial data out
rx_data  out  WORD_W+2  completed frame {op, word} to RAM
rx_valid  out  1  one-cycle strobe, rx_data valid
tx_data  in  WORD_W  read data from RAM
tx_valid  in  1  tx_data valid strobe
frame_err  out  1  one-cycle strobe on aborted/inconsistent/timed-out frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; MISO=0, rx_data=0, rx_valid=0, frame_err=0; bit counter=0; rd_addr_seen=0. Reset mid-frame discards everything; RAM sees no strobe.
- Op codes: 00 write addr, 01 write data, 10 read addr, 11 read data.
- IDLE: SS_n sampled 0 -> CHK_CMD.
- CHK_CMD: sample MOSI as cmd bit. 0 -> WRITE; 1 with rd_addr_seen=0 -> READ_ADD; 1 with rd_addr_seen=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift MOSI in MSB-first, one bit per edge, for WORD_W+2 edges. The register update on the edge sampling the last bit sets rx_data and pulses rx_valid for one cycle.
- Consistency check at that edge: WRITE requires op[1]=0, READ_ADD requires op=10, READ_DATA requires op=11. On mismatch: no rx_valid, frame_err pulse, rx_data unchanged, wait in state until SS_n=1.
- READ_ADD with a valid frame: set rd_addr_seen=1, then hold until SS_n=1.
- READ_DATA with a valid frame: wait for tx_valid.
  - tx_valid sampled 1: capture tx_data; MISO<=tx_data[WORD_W-1] on that edge, then the remaining bits on the next WORD_W-1 edges.
  - After the last bit: MISO<=0, clear rd_addr_seen, hold until SS_n=1.
  - No tx_valid within TX_TIMEOUT cycles after rx_valid: frame_err pulse, MISO stays 0, rd_addr_seen kept (read may be retried).
- tx_valid outside the wait phase is ignored.
- SS_n=1 sampled in any non-IDLE state: next state IDLE, MISO<=0. If fewer than WORD_W+2 payload bits were received (CHK_CMD included), frame_err pulses that edge and no rx_valid is issued.
- SS_n=1 during MISO shift-out: transfer truncated, rd_addr_seen NOT cleared, no frame_err.
- SS_n=1 in IDLE: no action. Back-to-back frames need only one IDLE cycle.
- rx_valid and frame_err are never high together.
- Bit counter is width $clog2(WORD_W+3), saturating and never wrapping. It is cleared on entry to CHK_CMD.

Decomposition:
- Package spi_slave_pkg:
  - state encoding IDLE/CHK_CMD/WRITE/READ_ADD/READ_DATA;
  - op-code constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
- Sub-module spi_tx_shifter (WORD_W): load/shift/done for MISO serialisation.
- Frame FSM, counter, checks and timeout stay in spi_slave_param.

Test Plan:
1. WORD_W=8. SS_n=0, cmd 0, payload 00_1111_1111, SS_n=1 -> one rx_valid, rx_data=10'h0FF, frame_err=0.
2. cmd 0, payload 01_0111_1101 -> rx_valid, rx_data=10'h17D. Then cmd 1, payload 10_1111_1111 -> rx_data=10'h2FF, rd_addr_seen=1.
3. cmd 1, payload 11_0000_0000 -> rx_data=10'h300. Model returns tx_valid with tx_data=8'h7D two cycles later -> MISO 0,1,1,1,1,1,0,1 on consecutive cycles from the tx_valid edge, then 0. rd_addr_seen=0.
4. SS_n=1 after 5 payload bits -> frame_err pulse, no rx_valid, IDLE next cycle. Next full write frame is accepted normally.
5. rd_addr_seen=0, cmd 1, payload 11_xxxx_xxxx -> frame_err, no rx_valid. Separately: READ_DATA with no tx_valid for 16 cycles -> frame_err, MISO=0, rd_addr_seen=1.
6. WORD_W=16: write addr 18'h0_1234, read-addr/read-data sequence, tx_data=16'hA5C3 -> 16 MISO bits MSB-first. Also assert rst_n=0 mid-shift -> MISO=0 immediately, state IDLE.
